// File: rtl/param_word_checker.sv
//==============================================================================
// Module   : param_word_checker
// Purpose  : Receive-side checker for a constant-pattern source. Over a window
//            of N_SAMPLES valid beats it compares every word against the
//            expected pattern Y, counts mismatches and reports pass/fail with a
//            one-cycle done pulse.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters:
//   X          data width in bits (>= 1)
//   Y          expected word, exactly X bits
//   N_SAMPLES  valid beats per check window (>= 1)
//   CW         (derived) width of the sample and error counters
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      begins a check window (sampled only in IDLE)
//   in_valid   in_data carries a valid beat this cycle
//   in_data    word under check [X-1:0]
//   busy       high while the window is running
//   done       one-cycle pulse when the window completes
//   pass       window result, 1 = zero mismatches (held until next start)
//   err_count  mismatches in the current or last window [CW-1:0]
// Optional (macro PARAM_WORD_CHECKER_FIRST_ERR_EN):
//   first_err_data  first mismatching word of the window [X-1:0]
//   first_err_idx   0-based beat index of that word [CW-1:0]
//==============================================================================
`default_nettype none

module param_word_checker #(
  parameter int            X         = 15,
  parameter logic [X-1:0]  Y         = {X{1'b1}},
  parameter int            N_SAMPLES = 16,
  localparam int           CW        = $clog2(N_SAMPLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [X-1:0]  in_data,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count
`ifdef PARAM_WORD_CHECKER_FIRST_ERR_EN
  ,
  output logic [X-1:0]  first_err_data,
  output logic [CW-1:0] first_err_idx
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Index of the final beat of a window; reaching it while a beat is
  // accepted closes the window.
  localparam logic [CW-1:0] c_last_idx = CW'(N_SAMPLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] sample_cnt_q, sample_cnt_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic          pass_q, pass_d;

  logic          w_mismatch;

  // Full-width unsigned compare; both operands are exactly X bits.
  assign w_mismatch = (in_data != Y);

`ifdef PARAM_WORD_CHECKER_FIRST_ERR_EN
  logic [X-1:0]  first_data_q, first_data_d;
  logic [CW-1:0] first_idx_q, first_idx_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      pass_q       <= 1'b0;
`ifdef PARAM_WORD_CHECKER_FIRST_ERR_EN
      first_data_q <= '0;
      first_idx_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      pass_q       <= pass_d;
`ifdef PARAM_WORD_CHECKER_FIRST_ERR_EN
      first_data_q <= first_data_d;
      first_idx_q  <= first_idx_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    pass_d       = pass_q;
`ifdef PARAM_WORD_CHECKER_FIRST_ERR_EN
    first_data_d = first_data_q;
    first_idx_d  = first_idx_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_RUN;
          sample_cnt_d = '0;
          err_cnt_d    = '0;
          pass_d       = 1'b0;
`ifdef PARAM_WORD_CHECKER_FIRST_ERR_EN
          first_data_d = '0;
          first_idx_d  = '0;
`endif
        end
      end

      S_RUN: begin
        if (in_valid) begin
          sample_cnt_d = sample_cnt_q + CW'(1);
          if (w_mismatch) begin
            err_cnt_d = err_cnt_q + CW'(1);
`ifdef PARAM_WORD_CHECKER_FIRST_ERR_EN
            // A zero error count means this is the window's first mismatch.
            if (err_cnt_q == '0) begin
              first_data_d = in_data;
              first_idx_d  = sample_cnt_q;
            end
`endif
          end
          if (sample_cnt_q == c_last_idx) begin
            state_d = S_DONE;
            // Use the updated count so the final beat is included.
            pass_d  = (err_cnt_d == '0);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_count = err_cnt_q;

`ifdef PARAM_WORD_CHECKER_FIRST_ERR_EN
  assign first_err_data = first_data_q;
  assign first_err_idx  = first_idx_q;
`endif

endmodule

`default_nettype wire
